// File: rtl/distram_pkg.sv
// distram_pkg: pointer type and pointer arithmetic shared by the distributed-RAM reader and writer.
// Helpers take a wide container plus the address width so any depth can reuse them.
`define DISTRAM_PTR_T(aw) logic [(aw):0]

package distram_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

    function automatic ptr_wide_t ptr_mask(input int aw);
        return (ptr_wide_t'(1) << (aw + 1)) - ptr_wide_t'(1);
    endfunction

    function automatic ptr_wide_t ptr_level(input ptr_wide_t wr, input ptr_wide_t rd, input int aw);
        return (wr - rd) & ptr_mask(aw);
    endfunction

    function automatic logic ptr_full(input ptr_wide_t wr, input ptr_wide_t rd, input int aw);
        return ((((wr ^ rd) >> aw) & ptr_wide_t'(1)) != '0) &&
               (((wr ^ rd) & (ptr_mask(aw) >> 1)) == '0);
    endfunction

endpackage

// File: rtl/distram_rd_stream_if.sv
// distram_rd_stream_if: RAM read port, pointer exchange and output stream of the buffer reader.
interface distram_rd_stream_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH:0]   WR_PTR;
    logic [ADDR_WIDTH-1:0] DPRA;
    logic [DATA_WIDTH-1:0] DPO;
    logic [ADDR_WIDTH:0]   RD_PTR;
    logic                  M_VALID;
    logic                  M_READY;
    logic [DATA_WIDTH-1:0] M_DATA;
    logic                  FLUSH;
    logic [ADDR_WIDTH:0]   LEVEL;
    logic                  ERR;

    modport master (
        input  WR_PTR, DPO, M_READY, FLUSH,
        output DPRA, RD_PTR, M_VALID, M_DATA, LEVEL, ERR
    );

    modport slave (
        output WR_PTR, DPO, M_READY, FLUSH,
        input  DPRA, RD_PTR, M_VALID, M_DATA, LEVEL, ERR
    );
endinterface

// File: rtl/distram_rd_stream.sv
// distram_rd_stream: reads a dual-port distributed RAM in order into a first-word-fall-through
// output register, returning its read pointer to the writer and flagging writer overruns.
module distram_rd_stream
    import distram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input logic CLK,
    input logic RST,
    distram_rd_stream_if.master bus
);

    localparam int PW = ADDR_WIDTH + 1;

    `DISTRAM_PTR_T(ADDR_WIDTH) rd_ptr_q, rd_ptr_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  err_q, err_d;
    logic                  empty, load, overrun;
    ptr_wide_t             level_w;

    assign level_w = ptr_level(ptr_wide_t'(bus.WR_PTR), ptr_wide_t'(rd_ptr_q), ADDR_WIDTH);
    assign overrun = level_w > (ptr_wide_t'(1) << ADDR_WIDTH);

    always_comb begin
        empty     = rd_ptr_q == bus.WR_PTR;
        load      = !empty && (!m_valid_q || bus.M_READY) && !bus.FLUSH;
        rd_ptr_d  = bus.FLUSH ? bus.WR_PTR : load ? rd_ptr_q + PW'(1) : rd_ptr_q;
        m_valid_d = bus.FLUSH ? 1'b0 : load ? 1'b1 : (m_valid_q && bus.M_READY) ? 1'b0 : m_valid_q;
        m_data_d  = load ? bus.DPO : m_data_q;
        err_d     = err_q || overrun;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    // DPO is asynchronous, so the address comes straight off the pointer flop.
    assign bus.DPRA    = rd_ptr_q[ADDR_WIDTH-1:0];
    assign bus.RD_PTR  = rd_ptr_q;
    assign bus.M_VALID = m_valid_q;
    assign bus.M_DATA  = m_data_q;
    assign bus.LEVEL   = PW'(level_w);
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_distram_rd_stream.sv
// tb_distram_rd_stream: directed checks of the RAM reader against a clocked bench writer
// and an asynchronous-read RAM model.
module tb_distram_rd_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] mem [16];
    logic [4:0] wr_ptr;
    logic       wr_en = 1'b0;
    logic [7:0] wr_din = '0;
    logic       wr_set = 1'b0;
    logic [4:0] wr_set_val = '0;

    int n_checks = 0;
    int n_fail = 0;
    int sent;
    int rcv;

    distram_rd_stream_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    distram_rd_stream #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) wr_ptr <= '0;
        else if (wr_set) wr_ptr <= wr_set_val;
        else if (wr_en) begin
            mem[wr_ptr[3:0]] <= wr_din;
            wr_ptr <= wr_ptr + 5'd1;
        end
    end

    assign bus.WR_PTR = wr_ptr;
    assign bus.DPO = mem[bus.DPRA];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        wr_din = d;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.M_READY = 1'b0;
        bus.FLUSH = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus.M_VALID, 0);
        chk("rst_rdptr", bus.RD_PTR, 0);
        chk("rst_data", bus.M_DATA, 0);
        chk("rst_err", bus.ERR, 0);
        chk("rst_dpra", bus.DPRA, 0);
        chk("rst_level", bus.LEVEL, 0);
        rst = 1'b0;
        @(negedge clk);

        // single entry: WR_PTR 0->1 at edge t, beat visible after t+1, gone after t+2
        bus.M_READY = 1'b1;
        push(8'hA5);
        chk("single_notyet", bus.M_VALID, 0);
        cyc(1);
        chk("single_valid", bus.M_VALID, 1);
        chk("single_data", bus.M_DATA, 8'hA5);
        chk("single_rdptr", bus.RD_PTR, 1);
        chk("single_dpra", bus.DPRA, 1);
        chk("single_level", bus.LEVEL, 0);
        cyc(1);
        chk("single_drop", bus.M_VALID, 0);

        // backpressure: first beat held, two left in RAM
        bus.M_READY = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("bp_valid", bus.M_VALID, 1);
        chk("bp_data", bus.M_DATA, 8'h11);
        chk("bp_rdptr", bus.RD_PTR, 2);
        chk("bp_level", bus.LEVEL, 2);
        cyc(1);
        chk("bp_hold", bus.M_DATA, 8'h11);
        bus.M_READY = 1'b1;
        cyc(1);
        chk("bp_data2", bus.M_DATA, 8'h22);
        chk("bp_valid2", bus.M_VALID, 1);
        cyc(1);
        chk("bp_data3", bus.M_DATA, 8'h33);
        chk("bp_valid3", bus.M_VALID, 1);
        cyc(1);
        chk("bp_done", bus.M_VALID, 0);
        chk("bp_level0", bus.LEVEL, 0);

        // wrap: 20 entries through a 16-deep RAM with random backpressure
        do_reset();
        sent = 0;
        rcv = 0;
        for (int i = 0; i < 600 && rcv < 20; i++) begin
            wr_en = (sent < 20) && (bus.LEVEL < 5'd16);
            wr_din = 8'(sent) ^ 8'h5A;
            if (wr_en) sent++;
            bus.M_READY = 1'($urandom_range(0, 1));
            if (bus.M_VALID && bus.M_READY) begin
                chk("wrap_data", bus.M_DATA, 8'(rcv) ^ 8'h5A);
                rcv++;
            end
            cyc(1);
        end
        wr_en = 1'b0;
        chk("wrap_count", rcv, 20);
        chk("wrap_rdptr", bus.RD_PTR, 5'b10100);
        chk("wrap_level", bus.LEVEL, 0);
        chk("wrap_idle", bus.M_VALID, 0);

        // full, then forced overrun sets a sticky ERR
        do_reset();
        bus.M_READY = 1'b0;
        for (int k = 0; k < 17; k++) push(8'(k + 8'hC0));
        chk("full_wrptr", bus.WR_PTR, 17);
        chk("full_rdptr", bus.RD_PTR, 1);
        chk("full_level", bus.LEVEL, 16);
        chk("full_err", bus.ERR, 0);
        chk("full_data", bus.M_DATA, 8'hC0);
        wr_set = 1'b1;
        wr_set_val = 5'd18;
        cyc(1);
        wr_set = 1'b0;
        cyc(1);
        chk("ovr_err", bus.ERR, 1);
        wr_set = 1'b1;
        wr_set_val = 5'd17;
        cyc(1);
        wr_set = 1'b0;
        cyc(2);
        chk("ovr_sticky", bus.ERR, 1);
        do_reset();
        chk("ovr_cleared", bus.ERR, 0);

        // flush discards the output beat and five pending entries
        bus.M_READY = 1'b0;
        for (int k = 0; k < 6; k++) push(8'(k + 8'h40));
        chk("fl_pre_level", bus.LEVEL, 5);
        chk("fl_pre_valid", bus.M_VALID, 1);
        bus.FLUSH = 1'b1;
        cyc(1);
        bus.FLUSH = 1'b0;
        chk("fl_valid", bus.M_VALID, 0);
        chk("fl_rdptr", bus.RD_PTR, 6);
        chk("fl_level", bus.LEVEL, 0);
        chk("fl_data_hold", bus.M_DATA, 8'h40);
        bus.M_READY = 1'b1;
        push(8'h77);
        cyc(1);
        chk("fl_next_valid", bus.M_VALID, 1);
        chk("fl_next_data", bus.M_DATA, 8'h77);

        // asynchronous reset between edges drops the beat at once
        bus.M_READY = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.M_VALID, 0);
        chk("arst_rdptr", bus.RD_PTR, 0);
        chk("arst_data", bus.M_DATA, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        chk("arst_idle", bus.M_VALID, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/distram_rd_stream.md
Name: distram_rd_stream

Overview:
Read-side controller for a same-clock dual-port distributed-RAM buffer. A separate writer owns the RAM write port and publishes its write pointer. This block:
- drives the RAM read-only address (DPRA),
- samples the asynchronous read data (DPO),
- presents entries in order on a valid/ready stream,
- returns its read pointer to the writer for full detection.

Parameters:
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM and stream data width.

Ports:
- CLK  input  1  single clock, shared with the RAM write clock.
- RST  input  1  asynchronous, active-high reset.
- WR_PTR  input  ADDR_WIDTH+1  writer pointer: MSB is the wrap bit, LSBs are the next write address.
- DPRA  output  ADDR_WIDTH  read-only address to the RAM.
- DPO  input  DATA_WIDTH  asynchronous RAM read data at DPRA.
- RD_PTR  output  ADDR_WIDTH+1  read pointer returned to the writer (same wrap-bit format).
- M_VALID  output  1  stream data valid.
- M_READY  input  1  stream consumer ready.
- M_DATA  output  DATA_WIDTH  stream data.
- FLUSH  input  1  synchronous discard of all pending data.
- LEVEL  output  ADDR_WIDTH+1  entries still in RAM, i.e. WR_PTR-RD_PTR modulo 2**(ADDR_WIDTH+1); excludes the output register.
- ERR  output  1  sticky overrun flag.

Behaviour:
- Reset (async assert, sync release): RD_PTR=0, M_VALID=0, M_DATA=0, ERR=0. DPRA follows RD_PTR, so it resets to 0. The writer resets WR_PTR to 0 on the same RST.
- DPRA = RD_PTR[ADDR_WIDTH-1:0], combinational. There is no registered address stage.
- empty = (RD_PTR == WR_PTR).
- Writer contract: the RAM write and the WR_PTR increment happen on the same CLK edge. Any address below WR_PTR therefore holds valid data on DPO, and no read/write same-address hazard exists.
- Output stage is a single first-word-fall-through register:
  - load = !empty && (!M_VALID || M_READY) && !FLUSH.
  - On load: M_DATA<=DPO, M_VALID<=1, RD_PTR<=RD_PTR+1 (wraps naturally in ADDR_WIDTH+1 bits).
  - Else if M_VALID && M_READY: M_VALID<=0.
  - Else: hold.
- Latency: WR_PTR increments at edge t while the output is idle, giving M_VALID=1 after edge t+1. Throughput is one entry per cycle under continuous M_READY.
- M_DATA and M_VALID are stable while M_VALID && !M_READY. M_READY may toggle freely and has no combinational path to M_VALID.
- FLUSH (highest priority after reset): RD_PTR<=WR_PTR and M_VALID<=0. M_DATA holds its old value. An entry handshaken in the FLUSH cycle counts as consumed.
- LEVEL is combinational from WR_PTR and RD_PTR. Range is 0 to 2**ADDR_WIDTH; full is LEVEL == 2**ADDR_WIDTH.
- ERR is set and held until RST when LEVEL > 2**ADDR_WIDTH (writer overran). Reading continues regardless.
- Reset mid-transfer: the M_VALID beat is dropped immediately, with no partial state.

Decomposition:
- Package distram_pkg holds:
  - ptr_t typedef: logic [ADDR_WIDTH:0], parameterised via a function or macro.
  - function ptr_level(wr,rd) returning the modulo difference.
  - function ptr_full(wr,rd) returning MSBs differ and LSBs equal, shared with the writer block.
- No sub-module: the pointer, output register and error flag are a single flat always_ff plus combinational assigns.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=8, behavioural RAM model driven by a bench writer):
- Single entry: write 0xA5 at addr 0 with WR_PTR 0->1 at edge t, M_READY=1 -> after edge t+1, M_VALID=1, M_DATA=0xA5, RD_PTR=1, DPRA=1. After edge t+2, M_VALID=0.
- Backpressure: write 0x11, 0x22, 0x33 with M_READY=0 -> M_VALID=1, M_DATA=0x11 held, RD_PTR=1, LEVEL=2. Raise M_READY -> 0x22 then 0x33 on consecutive cycles, then M_VALID=0 and LEVEL=0.
- Wrap: stream 20 entries of value i^0x5A with random M_READY -> all 20 received in order and RD_PTR ends at 5'b10100.
- Full and overrun: hold M_READY=0 with the output register loaded -> WR_PTR=17, RD_PTR=1, LEVEL=16, ERR=0. Force WR_PTR=18 -> ERR=1, still 1 after WR_PTR returns to a legal value, cleared only by RST.
- Flush: 5 pending and M_VALID=1, pulse FLUSH -> next cycle M_VALID=0, RD_PTR==WR_PTR, LEVEL=0. A subsequent write of 0x77 is delivered next.
- Async reset mid-stream: assert RST between edges while M_VALID=1 -> M_VALID=0, RD_PTR=0, M_DATA=0 immediately, before the next CLK edge.
